// File: rtl/mem_port_arbiter_pkg.sv
// hack_pkg: shared constants for the Hack memory-port arbiter.
package hack_pkg;
    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;
    localparam int HACK_DATA_W    = 16;
    localparam int HACK_ADDR_W    = 15;
endpackage

// File: rtl/mem_port_arbiter_pick.sv
// rr_pick: combinational winner select, first requester at or after the pointer.
module rr_pick
    import hack_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int MODE     = ARB_MODE_FIXED,
    localparam int IW      = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [IW-1:0]       i_ptr,
    output logic [IW-1:0]       o_idx,
    output logic                o_any
);
    logic [IW-1:0] w_base;
    logic [IW:0]   w_pos;

    // Scan from the far end so the last hit is the requester closest to the pointer.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_pos  = '0;
        w_base = (MODE == ARB_MODE_RR) ? i_ptr : '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_pos = {1'b0, w_base} + (IW+1)'(k);
            w_pos = (w_pos >= (IW+1)'(CHANNELS)) ? w_pos - (IW+1)'(CHANNELS) : w_pos;
            if (i_req[w_pos[IW-1:0]]) begin
                o_idx = w_pos[IW-1:0];
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: registered N-channel arbiter for the single data-memory port,
// fixed-priority or round-robin, with burst lock held by the current owner.
module mem_port_arbiter
    import hack_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = HACK_DATA_W,
    parameter int ADDR_W   = HACK_ADDR_W,
    parameter int MODE     = ARB_MODE_FIXED
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        req,
    input  logic [CHANNELS-1:0]        lock,
    input  logic [CHANNELS-1:0]        we_in,
    input  logic [CHANNELS*DATA_W-1:0] data_in,
    input  logic [CHANNELS*ADDR_W-1:0] addr_in,
    output logic [CHANNELS-1:0]        grant,
    output logic [DATA_W-1:0]          out,
    output logic                       write,
    output logic [ADDR_W-1:0]          address,
    output logic                       valid
);
    localparam int IW = $clog2(CHANNELS);

    logic [CHANNELS-1:0] r_grant;
    logic [DATA_W-1:0]   r_out;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic                r_valid;
    logic [IW-1:0]       r_idx;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       w_pick_idx;
    logic [IW-1:0]       w_idx;
    logic                w_pick_any;
    logic                w_hold;
    logic                w_any;

    rr_pick #(
        .CHANNELS(CHANNELS),
        .MODE    (MODE)
    ) u_pick (
        .i_req(req),
        .i_ptr(r_ptr),
        .o_idx(w_pick_idx),
        .o_any(w_pick_any)
    );

    // Only the current owner's lock counts, and only while it still requests.
    always_comb begin
        w_hold = |(r_grant & req & lock);
        w_idx  = w_hold ? r_idx : w_pick_idx;
        w_any  = w_hold | w_pick_any;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant <= '0;
            r_out   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_grant <= w_any ? CHANNELS'(1) << w_idx : '0;
            r_valid <= w_any;
            r_write <= w_any & we_in[w_idx];
            // Data/address hold when idle to keep the memory bus quiet.
            if (w_any) begin
                r_out  <= data_in[w_idx*DATA_W +: DATA_W];
                r_addr <= addr_in[w_idx*ADDR_W +: ADDR_W];
                r_idx  <= w_idx;
            end
            if (MODE == ARB_MODE_RR && w_pick_any && !w_hold)
                r_ptr <= (w_idx == IW'(CHANNELS - 1)) ? '0 : w_idx + IW'(1);
        end
    end

    assign grant   = r_grant;
    assign out     = r_out;
    assign write   = r_write;
    assign address = r_addr;
    assign valid   = r_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for a 2-channel fixed-priority and a
// 4-channel round-robin arbiter, plus a small memory fed by the round-robin port.
module tb_mem_port_arbiter;
    import hack_pkg::*;

    typedef struct {
        bit          dut;
        string       name;
        logic [3:0]  g;
        logic [15:0] o;
        logic        w;
        logic [14:0] a;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  a_req = '0, a_lk = '0, a_we = '0;
    logic [15:0] a_d[2];
    logic [14:0] a_a[2];
    logic [1:0]  a_grant;
    logic [15:0] a_out;
    logic        a_write, a_valid;
    logic [14:0] a_address;

    logic [3:0]  b_req = '0, b_lk = '0, b_we = '0;
    logic [15:0] b_d[4];
    logic [14:0] b_a[4];
    logic [3:0]  b_grant;
    logic [15:0] b_out;
    logic        b_write, b_valid;
    logic [14:0] b_address;

    mem_port_arbiter #(.CHANNELS(2), .MODE(ARB_MODE_FIXED)) dut_a (
        .clk(clk), .reset(reset), .req(a_req), .lock(a_lk), .we_in(a_we),
        .data_in({a_d[1], a_d[0]}), .addr_in({a_a[1], a_a[0]}),
        .grant(a_grant), .out(a_out), .write(a_write), .address(a_address), .valid(a_valid)
    );

    mem_port_arbiter #(.CHANNELS(4), .MODE(ARB_MODE_RR)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .lock(b_lk), .we_in(b_we),
        .data_in({b_d[3], b_d[2], b_d[1], b_d[0]}), .addr_in({b_a[3], b_a[2], b_a[1], b_a[0]}),
        .grant(b_grant), .out(b_out), .write(b_write), .address(b_address), .valid(b_valid)
    );

    logic        sys_en = 1'b0;
    logic [15:0] mem[32];
    initial for (int i = 0; i < 32; i++) mem[i] = '0;
    always @(posedge clk) if (sys_en && b_write) mem[b_address[4:0]] <= b_out;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void exp_a(string n, logic [1:0] g, logic [15:0] o, logic w, logic [14:0] ad, logic v);
        q.push_back('{1'b0, n, {2'b00, g}, o, w, ad, v});
    endfunction

    function automatic void exp_b(string n, logic [3:0] g, logic [15:0] o, logic w, logic [14:0] ad, logic v);
        q.push_back('{1'b1, n, g, o, w, ad, v});
    endfunction

    function automatic void exp_bi(string n, int idx);
        exp_b(n, 4'(1 << idx), b_d[idx], b_we[idx], b_a[idx], 1'b1);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(string n, logic [15:0] act, logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", n, act, want);
        end
    endtask

    // Monitor: every entry pushed at a negedge is due just after the next posedge.
    initial forever begin
        exp_t e;
        logic [3:0] g;
        logic [15:0] o;
        logic w, v;
        logic [14:0] ad;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e  = q.pop_front();
            g  = e.dut ? b_grant : {2'b00, a_grant};
            o  = e.dut ? b_out : a_out;
            w  = e.dut ? b_write : a_write;
            ad = e.dut ? b_address : a_address;
            v  = e.dut ? b_valid : a_valid;
            n_vec++;
            if ({g, o, w, ad, v} !== {e.g, e.o, e.w, e.a, e.v}) begin
                n_err++;
                $display("FAIL %s: got grant=%b out=%0d write=%b addr=%0d valid=%b, want grant=%b out=%0d write=%b addr=%0d valid=%b",
                         e.name, g, o, w, ad, v, e.g, e.o, e.w, e.a, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_d = '{16'd11, 16'd12};
        a_a = '{15'd3, 15'd4};
        for (int i = 0; i < 4; i++) begin
            b_d[i] = 16'h100 + 16'(i);
            b_a[i] = 15'd8 + 15'(i);
        end
        @(negedge clk);
        // Reset with every channel requesting.
        a_req = 2'b11; a_we = 2'b11; b_req = 4'b1111; b_we = 4'b1111; b_lk = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            exp_a("reset_a", 2'b00, 16'd0, 1'b0, 15'd0, 1'b0);
            exp_b("reset_b", 4'b0000, 16'd0, 1'b0, 15'd0, 1'b0);
            tick();
        end
        // Fixed priority, first grant straight out of reset.
        reset = 1'b1; b_req = '0; b_lk = '0;
        a_d[0] = 16'd2; a_a[0] = 15'd0; a_we = 2'b01; a_d[1] = 16'd7; a_a[1] = 15'd5;
        exp_a("m0_both", 2'b01, 16'd2, 1'b1, 15'd0, 1'b1);
        exp_b("b_idle_after_reset", 4'b0000, 16'd0, 1'b0, 15'd0, 1'b0);
        tick();
        a_req = 2'b10;
        exp_a("m0_ch1", 2'b10, 16'd7, 1'b0, 15'd5, 1'b1); tick();
        a_req = 2'b11; a_lk = 2'b10;
        exp_a("m0_lock_hold", 2'b10, 16'd7, 1'b0, 15'd5, 1'b1); tick();
        a_lk = 2'b01;
        exp_a("m0_nongrant_lock", 2'b01, 16'd2, 1'b1, 15'd0, 1'b1); tick();
        a_req = 2'b00; a_lk = 2'b00;
        exp_a("m0_idle", 2'b00, 16'd2, 1'b0, 15'd0, 1'b0); tick();
        a_req = 2'b01; a_we = 2'b00; a_d[0] = 16'd9; a_a[0] = 15'd3;
        exp_a("m0_read", 2'b01, 16'd9, 1'b0, 15'd3, 1'b1); tick();
        a_req = 2'b00;
        exp_a("m0_idle2", 2'b00, 16'd9, 1'b0, 15'd3, 1'b0); tick();
        // Round-robin over all four, then over channels 1 and 3.
        b_we = 4'b0101; b_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_bi("rr_1111", k % 4);
            tick();
        end
        b_req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_bi("rr_1010", (k % 2 == 0) ? 1 : 3);
            tick();
        end
        // Lock: ch2 holds for 5 cycles, then pointer resumes after 2.
        b_req = 4'b0100; b_lk = 4'b0100;
        exp_bi("lock_take", 2); tick();
        b_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_bi("lock_hold", 2);
            tick();
        end
        b_lk = 4'b0000;
        exp_bi("lock_release", 3); tick();
        b_lk = 4'b0001;
        exp_bi("lock_nonowner", 0); tick();
        exp_bi("lock_owner_hold", 0); tick();
        b_req = 4'b1110;
        exp_bi("lock_req_drop", 1); tick();
        // Idle holds out/address of the last access.
        b_lk = '0; b_req = 4'b0010; b_d[1] = 16'd23; b_a[1] = 15'd16; b_we = 4'b0010;
        exp_bi("idle_pre", 1); tick();
        b_req = 4'b0000;
        exp_b("idle_hold", 4'b0000, 16'd23, 1'b0, 15'd16, 1'b0); tick();
        exp_b("idle_hold2", 4'b0000, 16'd23, 1'b0, 15'd16, 1'b0); tick();
        // System: locked loader burst on ch1 while the CPU (ch0) waits.
        sys_en = 1'b1;
        b_we = 4'b0011; b_d[0] = 16'd23; b_a[0] = 15'd16; b_d[1] = 16'd2; b_a[1] = 15'd0;
        b_req = 4'b0010; b_lk = 4'b0010;
        exp_bi("sys_load0", 1); tick();
        b_d[1] = 16'd7; b_a[1] = 15'd1; b_req = 4'b0011;
        exp_bi("sys_load1", 1); tick();
        b_req = 4'b0001; b_lk = 4'b0000;
        exp_bi("sys_cpu", 0); tick();
        b_req = 4'b0000;
        exp_b("sys_idle", 4'b0000, 16'd23, 1'b0, 15'd16, 1'b0); tick();
        tick();
        chk("ram0", mem[0], 16'd2);
        chk("ram1", mem[1], 16'd7);
        chk("ram16", mem[16], 16'd23);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
